// File: rtl/noc_led_arb_pkg.sv
// Shared types and constants for the NOC LED PIO arbiter.
// Imported by noc_led_rr_picker and noc_led_arbiter.
package noc_led_arb_pkg;

  localparam int          LED_W_DEFAULT = 10;
  localparam int          ID_W          = 3;
  localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/noc_led_rr_picker.sv
// Combinational round-robin picker: the search starts one past last_grant.
// Generic enough for any NOC shared-peripheral arbiter with up to 8 requesters.
module noc_led_rr_picker
  import noc_led_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               valid,
  output logic [ID_W-1:0]    winner
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  int                   offset;
  int                   sum;

  // Rotate so bit 0 is the requester just after last_grant; the lowest set bit wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    doubled = {req, req} >> (int'(last_grant) + 1);
    rotated = doubled[NUM_REQ-1:0];
    valid   = 1'b0;
    offset  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        valid  = 1'b1;
        offset = k;
      end
    end
    sum = int'(last_grant) + 1 + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    winner = ID_W'(sum);
  end

endmodule

// File: rtl/noc_led_arbiter.sv
// Round-robin arbiter doing atomic read-modify-write of the LED PIO for NUM_REQ requesters.
// Define NOC_LED_ARB_SHADOW_EN to merge against an internal shadow register and skip the PIO read.
module noc_led_arbiter
  import noc_led_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LED_W   = LED_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] req_mask,
  input  logic [NUM_REQ*LED_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic [1:0]               pio_address,
  output logic                     pio_chipselect,
  output logic                     pio_write_n,
  output logic [31:0]              pio_writedata,
  input  logic [31:0]              pio_readdata
);

  state_t            state, state_nxt;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   last_grant;
  logic [LED_W-1:0]  mask_q, data_q;
  logic [LED_W-1:0]  base, merged;

  noc_led_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_id)
  );

`ifdef NOC_LED_ARB_SHADOW_EN
  localparam state_t GRANT_NEXT = WRITE;
  logic [LED_W-1:0] shadow_q;
  logic             unused_readdata;

  assign unused_readdata = ^pio_readdata;
  assign base            = shadow_q;

  // The shadow mirrors the PIO because this arbiter is its only writer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               shadow_q <= '0;
    else if (state == WRITE) shadow_q <= merged;
  end
`else
  localparam state_t GRANT_NEXT = READ;
  logic [LED_W-1:0] rd_q;
  logic             unused_readdata;

  assign unused_readdata = ^pio_readdata[31:LED_W];
  assign base            = rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              rd_q <= '0;
    else if (state == READ) rd_q <= pio_readdata[LED_W-1:0];
  end
`endif

  assign merged = (base & ~mask_q) | (data_q & mask_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = GRANT_NEXT;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The request is captured at grant, so later changes on req/mask/data do not disturb it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      mask_q     <= '0;
      data_q     <= '0;
    end else if (state == IDLE && pick_valid) begin
      last_grant <= pick_id;
      grant_id   <= pick_id;
      mask_q     <= req_mask[pick_id*LED_W +: LED_W];
      data_q     <= req_data[pick_id*LED_W +: LED_W];
    end
  end

  // Outputs decode only state and registers, never req directly.
  always_comb begin
    busy           = (state != IDLE);
    ack            = '0;
    pio_address    = PIO_DATA_ADDR;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    case (state)
      READ: pio_chipselect = 1'b1;
      WRITE: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_writedata  = {{(32-LED_W){1'b0}}, merged};
      end
      ACK:     ack = NUM_REQ'(1) << grant_id;
      default: ;
    endcase
  end

endmodule
